// File: rtl/gate_vector_checker_if.sv
// Bundle of run-control, gate-drive and result signals for gate_vector_checker.
interface gate_vector_checker_if;
  logic       start;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [1:0] fail_idx;

  // Checker side: receives start and the gate response, drives the gate and results.
  modport slave (
    input  start, c,
    output a, b, busy, done, pass, err_count, fail_idx
  );

  // Controller side: requests runs, supplies the gate response, observes results.
  modport master (
    output start, c,
    input  a, b, busy, done, pass, err_count, fail_idx
  );
endinterface

// File: rtl/gate_vector_checker.sv
// Exhaustive 2-input gate checker: steps {a,b} through 00,01,10,11, holds each
// vector DWELL cycles, compares c against EXPECT at the end of each dwell.
// Optional macro GATE_VECTOR_CHECKER_LOOP_EN: DONE re-enters DRIVE while start
// stays high, accumulating errors across passes.
module gate_vector_checker #(
  parameter int unsigned DWELL  = 10,       // cycles per vector, 2..255
  parameter logic [3:0]  EXPECT = 4'b0111   // expected c per index {a,b}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gate_vector_checker_if.slave  bus
);

  localparam int unsigned DWELL_W = 8;
  localparam int unsigned ERR_W   = 3;
  localparam int unsigned IDX_W   = 2;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [ERR_W-1:0]   ERR_MAX    = '1;
  localparam logic [IDX_W-1:0]   IDX_LAST   = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [IDX_W-1:0]   idx,       idx_nx;
  logic [DWELL_W-1:0] dwell,     dwell_nx;
  logic [ERR_W-1:0]   err_count, err_count_nx;
  logic [IDX_W-1:0]   fail_idx,  fail_idx_nx;
  logic               done,      done_nx;
  logic               pass,      pass_nx;
  logic               a,         a_nx;
  logic               b,         b_nx;
  logic               busy,      busy_nx;
  logic               cmp_c;

  // Last cycle of a vector's dwell: the only cycle c is looked at.
  assign cmp_c = (state == DRIVE) && (dwell == DWELL_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = DRIVE;
      DRIVE:   if (cmp_c && (idx == IDX_LAST)) state_nx = DONE;
`ifdef GATE_VECTOR_CHECKER_LOOP_EN
      DONE:    state_nx = bus.start ? DRIVE : IDLE;
`else
      DONE:    state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the datapath and registered outputs.
  always_comb begin
    idx_nx       = idx;
    dwell_nx     = dwell;
    err_count_nx = err_count;
    fail_idx_nx  = fail_idx;
    done_nx      = done;
    pass_nx      = pass;
    a_nx         = 1'b0;
    b_nx         = 1'b0;
    busy_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          idx_nx       = '0;
          dwell_nx     = '0;
          err_count_nx = '0;
          fail_idx_nx  = '0;
          done_nx      = 1'b0;
          pass_nx      = 1'b0;
        end
      end
      DRIVE: begin
        // In continuous mode this turns the per-pass done into a one-cycle pulse.
        done_nx = 1'b0;
        if (cmp_c) begin
          dwell_nx = '0;
          idx_nx   = idx + IDX_W'(1);
          if (bus.c != EXPECT[idx]) begin
            if (err_count == '0)      fail_idx_nx  = idx;
            if (err_count != ERR_MAX) err_count_nx = err_count + ERR_W'(1);
          end
        end else begin
          dwell_nx = dwell + DWELL_W'(1);
        end
      end
      DONE: begin
        done_nx  = 1'b1;
        pass_nx  = (err_count == '0);
        idx_nx   = '0;
        dwell_nx = '0;
      end
      default: begin
        idx_nx   = '0;
        dwell_nx = '0;
      end
    endcase
    // Gate inputs follow the vector that will be held during the next cycle.
    if (state_nx == DRIVE) begin
      a_nx    = idx_nx[1];
      b_nx    = idx_nx[0];
      busy_nx = 1'b1;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      dwell     <= '0;
      err_count <= '0;
      fail_idx  <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
    end else begin
      idx       <= idx_nx;
      dwell     <= dwell_nx;
      err_count <= err_count_nx;
      fail_idx  <= fail_idx_nx;
      done      <= done_nx;
      pass      <= pass_nx;
      a         <= a_nx;
      b         <= b_nx;
      busy      <= busy_nx;
    end
  end

  assign bus.a         = a;
  assign bus.b         = b;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pass      = pass;
  assign bus.err_count = err_count;
  assign bus.fail_idx  = fail_idx;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: a behavioural gate feeds c, a scoreboard holds
// the expected result of each run and is checked whenever done rises.
module tb_gate_vector_checker;

  localparam int unsigned D      = 10;
  localparam logic [3:0]  EXP_TB = 4'b0111;
  localparam int          M_NAND = 0;
  localparam int          M_ZERO = 1;
  localparam int          M_AND  = 2;

  typedef struct packed {
    logic [2:0] err;
    logic [1:0] fail;
    logic       pass;
  } exp_t;

  logic  clk;
  logic  rst_n;
  int    mode;
  int    n_checks;
  int    n_fail;
  int    done_rises;
  logic  done_prev;
  exp_t  sb[$];

  gate_vector_checker_if bus_i();

  gate_vector_checker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_i.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural gate under check.
  function automatic logic gate_fn(input int m, input logic ga, input logic gb);
    case (m)
      M_NAND:  gate_fn = ~(ga & gb);
      M_ZERO:  gate_fn = 1'b0;
      default: gate_fn = ga & gb;
    endcase
  endfunction

  assign bus_i.c = gate_fn(mode, bus_i.a, bus_i.b);

  // Expected result of one pass starting from a given error state.
  function automatic exp_t model(input int m, input logic [2:0] err_in, input logic [1:0] fail_in);
    exp_t       e;
    logic [3:0] expv;
    logic [1:0] ii;
    logic       cv;
    expv   = EXP_TB;
    e.err  = err_in;
    e.fail = fail_in;
    for (int i = 0; i < 4; i++) begin
      ii = 2'(i);
      cv = gate_fn(m, ii[1], ii[0]);
      if (cv != expv[i]) begin
        if (e.err == 3'd0) e.fail = ii;
        if (e.err != 3'd7) e.err = e.err + 3'd1;
      end
    end
    e.pass = (e.err == 3'd0);
    return e;
  endfunction

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: compare results each time done rises.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus_i.done && !done_prev) begin
      done_rises++;
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        check_eq("sb_err_count", 32'(bus_i.err_count), 32'(e.err));
        check_eq("sb_fail_idx",  32'(bus_i.fail_idx),  32'(e.fail));
        check_eq("sb_pass",      32'(bus_i.pass),      32'(e.pass));
      end
    end
    done_prev <= bus_i.done;
  end

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_a"},    32'(bus_i.a), 0);
    check_eq({tag, "_b"},    32'(bus_i.b), 0);
    check_eq({tag, "_busy"}, 32'(bus_i.busy), 0);
    check_eq({tag, "_done"}, 32'(bus_i.done), 0);
    check_eq({tag, "_pass"}, 32'(bus_i.pass), 0);
    check_eq({tag, "_err"},  32'(bus_i.err_count), 0);
    check_eq({tag, "_fail"}, 32'(bus_i.fail_idx), 0);
  endtask

  // One single-shot run; optionally re-pulse start during DRIVE.
  task automatic run(input int m, input bit repulse);
    exp_t e;
    e = model(m, 3'd0, 2'd0);
    @(negedge clk);
    mode = m;
    bus_i.start = 1'b1;
    sb.push_back(e);
    @(negedge clk);                       // just after acceptance edge k
    bus_i.start = 1'b0;
    check_eq("acc_err",  32'(bus_i.err_count), 0);
    check_eq("acc_fail", 32'(bus_i.fail_idx), 0);
    check_eq("acc_done", 32'(bus_i.done), 0);
    check_eq("acc_busy", 32'(bus_i.busy), 1);
    check_eq("ab_step",  32'({bus_i.a, bus_i.b}), 0);
    for (int i = 1; i < 4; i++) begin
      for (int j = 0; j < int'(D); j++) begin
        @(negedge clk);
        bus_i.start = (repulse && i == 2 && j == 0);
      end
      check_eq("ab_step", 32'({bus_i.a, bus_i.b}), 32'(i));
      check_eq("busy_mid", 32'(bus_i.busy), 1);
    end
    repeat (D) @(negedge clk);            // after edge k+4*D
    check_eq("done_early", 32'(bus_i.done), 0);
    @(negedge clk);                       // after edge k+4*D+1
    check_eq("done_k41", 32'(bus_i.done), 1);
    check_eq("busy_end", 32'(bus_i.busy), 0);
    check_eq("ab_end",   32'({bus_i.a, bus_i.b}), 0);
    repeat (5) @(negedge clk);
    check_eq("hold_done", 32'(bus_i.done), 1);
    check_eq("hold_err",  32'(bus_i.err_count), 32'(e.err));
    check_eq("hold_pass", 32'(bus_i.pass), 32'(e.pass));
  endtask

  task automatic wait_rises(input int target, input int budget);
    for (int n = 0; n < budget && done_rises < target; n++) @(negedge clk);
    check_eq("done_wait", 32'(done_rises >= target), 1);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    done_rises  = 0;
    done_prev   = 1'b0;
    mode        = M_NAND;
    rst_n       = 1'b0;
    bus_i.start = 1'b0;
    #12;
    check_idle_zero("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    run(M_NAND, 1'b0);
    run(M_ZERO, 1'b0);
    run(M_AND,  1'b0);
    run(M_NAND, 1'b0);                    // counters cleared after an erroring run
    run(M_NAND, 1'b1);                    // start during DRIVE ignored

    // Reset in the middle of vector idx=2.
    @(negedge clk);
    mode = M_ZERO;
    bus_i.start = 1'b1;
    @(negedge clk);
    bus_i.start = 1'b0;
    repeat (2 * D) @(negedge clk);
    check_eq("pre_rst_ab",  32'({bus_i.a, bus_i.b}), 2);
    check_eq("pre_rst_err", 32'(bus_i.err_count), 2);
    #2 rst_n = 1'b0;
    #1 check_idle_zero("mid_rst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    run(M_NAND, 1'b0);                    // start on first edge after release

`ifdef GATE_VECTOR_CHECKER_LOOP_EN
    begin
      exp_t e;
      logic [2:0] er;
      logic [1:0] fr;
      int base;
      er = 3'd0;
      fr = 2'd0;
      for (int p = 0; p < 3; p++) begin
        e = model(M_ZERO, er, fr);
        sb.push_back(e);
        er = e.err;
        fr = e.fail;
      end
      base = done_rises;
      @(negedge clk);
      mode = M_ZERO;
      bus_i.start = 1'b1;
      wait_rises(base + 1, 4 * int'(D) + 10);
      @(negedge clk);
      check_eq("loop_pulse", 32'(bus_i.done), 0);
      check_eq("loop_busy",  32'(bus_i.busy), 1);
      wait_rises(base + 2, 4 * int'(D) + 10);
      bus_i.start = 1'b0;
      wait_rises(base + 3, 4 * int'(D) + 10);
      repeat (5) @(negedge clk);
      check_eq("loop_idle_busy", 32'(bus_i.busy), 0);
      check_eq("loop_idle_done", 32'(bus_i.done), 1);
      check_eq("loop_sat_err",   32'(bus_i.err_count), 7);
    end
`endif

    repeat (3) @(negedge clk);
    check_eq("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_vector_checker.md
GATE_VECTOR_CHECKER -- requirements
Module: gate_vector_checker

Interface
REQ-001 SHALL provide parameter DWELL, default 10, meaning cycles each input vector is held (legal range 2..255).
REQ-002 SHALL provide parameter EXPECT, default 4'b0111, meaning the expected output per vector index {a,b}; bit i is the expected c for index i (default = 2-input NAND).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  run request, sampled on clk.
REQ-006 SHALL have port a  output  1  gate input a to device under check, registered.
REQ-007 SHALL have port b  output  1  gate input b to device under check, registered.
REQ-008 SHALL have port c  input  1  gate output from device under check.
REQ-009 SHALL have port busy  output  1  high while vectors are being driven.
REQ-010 SHALL have port done  output  1  run complete, held until next accepted start.
REQ-011 SHALL have port pass  output  1  valid when done=1; 1 = zero mismatches.
REQ-012 SHALL have port err_count  output  3  mismatch count for the run.
REQ-013 SHALL have port fail_idx  output  2  vector index {a,b} of the first mismatch; 0 if none.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, DONE; IDLE on reset.
REQ-015 IDLE: a=b=0, busy=0; start=1 SHALL move to DRIVE with idx=0, dwell=0, and clear err_count, fail_idx, done, pass on the same edge.
REQ-016 start while in DRIVE SHALL be ignored.
REQ-017 DRIVE: a=idx[1], b=idx[0], busy=1; dwell SHALL increment each cycle from 0 to DWELL-1.
REQ-018 On the cycle dwell==DWELL-1, c SHALL be compared to EXPECT[idx]; on mismatch err_count increments, and fail_idx<=idx if err_count was 0.
REQ-019 On that same cycle dwell SHALL reset to 0 and idx increment; if idx==3, the next state SHALL be DONE.
REQ-020 An accepted start at edge k SHALL produce DRIVE for edges k+1..k+4*DWELL, and done=1 and busy=0 after edge k+4*DWELL+1.
REQ-021 DONE: done<=1, pass<=(err_count==0 including the final comparison), a=b=0; next state SHALL be IDLE after one cycle.
REQ-022 done, pass, err_count, fail_idx SHALL hold in IDLE until the next accepted start.
REQ-023 err_count SHALL saturate at 7; it never wraps.
REQ-024 c SHALL be sampled only on comparison cycles; other values of c SHALL have no effect.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, idx=0, dwell=0, a=b=0, busy=0, done=0, pass=0, err_count=0, fail_idx=0, including mid-run.
REQ-026 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro GATE_VECTOR_CHECKER_LOOP_EN SHALL select continuous mode when defined.
REQ-028 With the macro defined, DONE SHALL go to DRIVE with idx=0 while start=1 on that edge, without clearing err_count or fail_idx, and done SHALL pulse for one cycle per pass; if start=0, DONE SHALL go to IDLE.
REQ-029 With the macro undefined, behaviour SHALL be single-pass exactly as REQ-021.

Verification
REQ-030 Correct NAND on c, defaults, 1-cycle start -> a,b step 00,01,10,11 every 10 cycles; done=1 after 41 edges; pass=1, err_count=0.
REQ-031 c tied 0 -> err_count=3, fail_idx=0, pass=0.
REQ-032 c = a AND b -> err_count=4, fail_idx=0, pass=0; then start again -> counters cleared at acceptance.
REQ-033 rst_n low during vector idx=2 -> all outputs 0 immediately, FSM IDLE; a new start runs a full clean pass.
REQ-034 start re-pulsed during DRIVE -> ignored; completion still at edge k+41.
REQ-035 LOOP_EN defined, start held high, c tied 0 -> err_count 3 then 6 then saturates at 7; done pulses once per pass; start dropped -> IDLE after the current DONE.
